// File: rtl/probe_target_pkg.sv
// Shared types and default constants for the probe target counter.
package probe_target_pkg;

    localparam int DATA_W = 16;

    typedef logic [DATA_W-1:0] data_t;

    localparam data_t INIT_VAL = 16'h0000;
    localparam data_t STEP_VAL = 16'h0001;

endpackage : probe_target_pkg

// File: rtl/probe_target_if.sv
// Observation bundle for the probe target value.
// The master side publishes the counter value and the slave side watches it.
interface probe_target_if;
    import probe_target_pkg::*;

    data_t value;

    modport master (output value);
    modport slave  (input  value);

endinterface : probe_target_if

// File: rtl/probe_target_top.sv
// Free-running counter used as a probe/force target.
// The state lives in `r`, and `out` is a separate net driven from it by one
// continuous assignment. Keeping them apart means a force on `out` can never
// disturb `r`, while a force on `r` still shows through on `out`.
module probe_target_top
    import probe_target_pkg::*;
#(
    parameter int               WIDTH = DATA_W,
    parameter logic [WIDTH-1:0] INIT  = INIT_VAL,
    parameter logic [WIDTH-1:0] STEP  = STEP_VAL
) (
    input  logic             clock,
    input  logic             reset,
    output wire  [WIDTH-1:0] out
);

    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] r_d;

    // Next count: load INIT while reset is low, otherwise advance by STEP with natural wrap.
    always_comb begin
        r_d = r + STEP;
        if (!reset) begin
            r_d = INIT;
        end
    end

    // State register; this is the only place `r` is assigned.
    always_ff @(posedge clock) begin
        r <= r_d;
    end

    assign out = r;

endmodule : probe_target_top

// File: tb/tb_probe_target_top.sv
// Directed bench for probe_target_top, covering reset, counting, wrap and the force/release contract.
module tb_probe_target_top;
    import probe_target_pkg::*;

    logic  clock;
    logic  reset;
    data_t out_w;

    int assert_count;
    int fail_count;

    probe_target_if mon_if ();

    probe_target_top dut (
        .clock (clock),
        .reset (reset),
        .out   (out_w)
    );

    assign mon_if.value = out_w;

    // Free-running clock with a 10 time-unit period.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check_output(input string tag, input data_t observed, input data_t expected);
        assert_count++;
        assert (observed === expected)
        else begin
            fail_count++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input int edges);
        repeat (edges) @(posedge clock);
        @(negedge clock);
    endtask

    // Linear sequence of directed steps.
    initial begin
        assert_count = 0;
        fail_count   = 0;
        reset        = 1'b0;

        // Synchronous reset held for two edges.
        apply_stimulus(2);
        check_output("reset_r", dut.r, 16'h0000);
        check_output("reset_out", dut.out, 16'h0000);

        // Releasing reset changes nothing until the next edge.
        reset = 1'b1;
        #1;
        check_output("release_r", dut.r, 16'h0000);
        check_output("release_out", out_w, 16'h0000);

        // Three counting edges.
        apply_stimulus(3);
        check_output("count3_r", dut.r, 16'h0003);
        check_output("count3_out", dut.out, 16'h0003);
        check_output("count3_if", mon_if.value, 16'h0003);

        // Preload 0xFFFF, release, one edge wraps to zero.
        force dut.r = 16'hffff;
        #1;
        check_output("preload_out", dut.out, 16'hffff);
        release dut.r;
        #1;
        check_output("preload_held_r", dut.r, 16'hffff);
        apply_stimulus(1);
        check_output("wrap_r", dut.r, 16'h0000);
        check_output("wrap_out", dut.out, 16'h0000);

        // Reset asserted mid-count while r = 0x1234.
        force dut.r = 16'h1234;
        #1;
        release dut.r;
        reset = 1'b0;
        apply_stimulus(1);
        check_output("midreset_r", dut.r, 16'h0000);
        check_output("midreset_out", dut.out, 16'h0000);
        reset = 1'b1;
        apply_stimulus(1);
        check_output("resume_r", dut.r, 16'h0001);
        check_output("resume_out", dut.out, 16'h0001);

        // Force only out; r must keep counting underneath.
        force dut.r = 16'h0004;
        #1;
        release dut.r;
        force dut.out = 16'hbeef;
        #1;
        check_output("fout_r0", dut.r, 16'h0004);
        check_output("fout_out0", dut.out, 16'hbeef);
        apply_stimulus(1);
        check_output("fout_r1", dut.r, 16'h0005);
        check_output("fout_out1", dut.out, 16'hbeef);
        apply_stimulus(1);
        check_output("fout_r2", dut.r, 16'h0006);
        check_output("fout_out2", dut.out, 16'hbeef);
        release dut.out;
        #1;
        check_output("rel_out", dut.out, 16'h0006);

        // Force r and out together; each holds its own value.
        force dut.r   = 16'hdead;
        force dut.out = 16'hbeef;
        #1;
        check_output("both_r0", dut.r, 16'hdead);
        check_output("both_out0", dut.out, 16'hbeef);
        apply_stimulus(1);
        check_output("both_r1", dut.r, 16'hdead);
        check_output("both_out1", dut.out, 16'hbeef);
        apply_stimulus(1);
        check_output("both_r2", dut.r, 16'hdead);
        check_output("both_out2", dut.out, 16'hbeef);

        // Drop the out force; out now follows the forced r.
        release dut.out;
        #1;
        check_output("fr_out0", dut.out, 16'hdead);
        apply_stimulus(2);
        check_output("fr_r2", dut.r, 16'hdead);
        check_output("fr_out2", dut.out, 16'hdead);

        // Release r; it resumes counting from the forced value.
        release dut.r;
        #1;
        check_output("relr_hold", dut.r, 16'hdead);
        apply_stimulus(1);
        check_output("relr_r", dut.r, 16'hdeae);
        check_output("relr_out", dut.out, 16'hdeae);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule : tb_probe_target_top
